// File: rtl/eth_pkg.sv
// Shared Ethernet/UDP definitions: header size, default payload-RAM geometry
// (common to the RX RAM writer, this reader and the UDP instantiation) and
// the payload reader state encoding.
package eth_pkg;

    localparam logic [15:0] UDP_HDR_BYTES = 16'd8;

    localparam int DEF_RAM_ADDR_W    = 9;
    localparam int DEF_RAM_DATA_W    = 32;
    localparam int DEF_RAM_BASE_ADDR = 0;
    localparam int DEF_RAM_RD_LAT    = 1;
    localparam int DEF_RAM_MAX_BYTES = 4 * (2 ** DEF_RAM_ADDR_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } rd_state_t;

    // Payload size from the UDP length field; wraps in 16 bits for short lengths.
    function automatic logic [15:0] payload_bytes(input logic [15:0] udp_len);
        return udp_len - UDP_HDR_BYTES;
    endfunction

endpackage

// File: rtl/udp_payload_reader_word_byte_unpacker.sv
// word_byte_unpacker: holds one 32-bit RAM word and presents its bytes MSB
// first. The selected byte only changes on load or advance, so it stays
// stable while the downstream stalls.
module word_byte_unpacker
    import eth_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_load,
    input  logic [DEF_RAM_DATA_W-1:0] i_word,
    input  logic                      i_advance,
    output logic [7:0]                o_byte,
    output logic                      o_idx_last
);

    logic [DEF_RAM_DATA_W-1:0] r_word;
    logic [1:0]                r_idx;

    // Word register and byte index: load restarts at byte 0, advance steps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= '0;
            r_idx  <= 2'd0;
        end else if (i_load) begin
            r_word <= i_word;
            r_idx  <= 2'd0;
        end else if (i_advance) begin
            r_idx  <= r_idx + 2'd1;
        end
    end

    // Byte select, bits [31:24] first.
    always_comb begin
        o_byte = r_word[31:24];
        case (r_idx)
            2'd0:    o_byte = r_word[31:24];
            2'd1:    o_byte = r_word[23:16];
            2'd2:    o_byte = r_word[15:8];
            default: o_byte = r_word[7:0];
        endcase
    end

    assign o_idx_last = (r_idx == 2'd3);

endmodule

// File: rtl/udp_payload_reader.sv
// udp_payload_reader: drains a received UDP payload from the payload RAM
// read port as a valid/ready byte stream, bounded by the UDP length field.
// Optional build macro PAYLOAD_SUM_EN adds sum_out/sum_valid (16-bit
// modular byte sum of the frame, pulsed the cycle after the last byte).
module udp_payload_reader
    import eth_pkg::*;
#(
    parameter int ADDR_W     = DEF_RAM_ADDR_W,
    parameter int BASE_ADDR  = DEF_RAM_BASE_ADDR,
    parameter int RAM_RD_LAT = DEF_RAM_RD_LAT,
    parameter int MAX_BYTES  = DEF_RAM_MAX_BYTES
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      frame_done,
    input  logic [15:0]               udp_length,
    output logic [ADDR_W-1:0]         ram_rd_addr,
    input  logic [DEF_RAM_DATA_W-1:0] ram_rd_data,
    output logic [7:0]                m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      m_last,
    output logic                      busy,
    output logic                      trunc,
    output logic [7:0]                drop_cnt
`ifdef PAYLOAD_SUM_EN
    ,
    output logic [15:0]               sum_out,
    output logic                      sum_valid
`endif
);

    localparam logic [15:0]       MAX_B     = 16'(MAX_BYTES);
    localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
    localparam logic [1:0]        LAT_LAST  = 2'(RAM_RD_LAT);

    rd_state_t         r_state;
    rd_state_t         w_state_nxt;
    logic [15:0]       r_remaining;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_lat_cnt;
    logic              r_trunc;
    logic [7:0]        r_drop;

    logic [15:0]       w_bytes;
    logic              w_has_payload;
    logic              w_over;
    logic [15:0]       w_count;
    logic              w_accept;
    logic              w_start;
    logic              w_load;
    logic              w_hs;
    logic              w_final;
    logic              w_idx_last;

    assign w_bytes       = payload_bytes(udp_length);
    assign w_has_payload = (udp_length > UDP_HDR_BYTES);
    assign w_over        = (w_bytes > MAX_B);
    assign w_count       = w_over ? MAX_B : w_bytes;

    // New frames are taken only in IDLE; empty payloads are accepted but start nothing.
    assign w_accept = (r_state == IDLE) && frame_done;
    assign w_start  = w_accept && w_has_payload;
    // The RAM word is valid once the address has been stable for RAM_RD_LAT cycles.
    assign w_load   = (r_state == WAIT) && (r_lat_cnt == LAT_LAST);
    assign w_hs     = m_valid && m_ready;
    assign w_final  = w_hs && (r_remaining == 16'd1);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        m_valid     = 1'b0;
        m_last      = 1'b0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (w_load) begin
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                busy    = 1'b1;
                m_valid = 1'b1;
                m_last  = (r_remaining == 16'd1);
                if (w_hs) begin
                    if (r_remaining == 16'd1) begin
                        w_state_nxt = IDLE;
                    end else if (w_idx_last) begin
                        w_state_nxt = WAIT;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // RAM latency counter, running only while waiting for a word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lat_cnt <= 2'd0;
        end else if ((r_state == WAIT) && !w_load) begin
            r_lat_cnt <= r_lat_cnt + 2'd1;
        end else begin
            r_lat_cnt <= 2'd0;
        end
    end

    // Remaining byte count and RAM word address (wraps modulo 2^ADDR_W).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_remaining <= 16'd0;
            r_addr      <= ADDR_BASE;
        end else if (w_start) begin
            r_remaining <= w_count;
            r_addr      <= ADDR_BASE;
        end else if (w_hs) begin
            r_remaining <= r_remaining - 16'd1;
            if (w_idx_last) begin
                r_addr <= r_addr + 1'b1;
            end
        end
    end

    // Sticky truncation flag and saturating count of frames dropped while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trunc <= 1'b0;
            r_drop  <= 8'd0;
        end else begin
            if (w_accept) begin
                r_trunc <= w_has_payload && w_over;
            end
            if (frame_done && (r_state != IDLE) && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
        end
    end

    word_byte_unpacker u_unpack (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_word     (ram_rd_data),
        .i_advance  (w_hs),
        .o_byte     (m_data),
        .o_idx_last (w_idx_last)
    );

    assign ram_rd_addr = r_addr;
    assign trunc       = r_trunc;
    assign drop_cnt    = r_drop;

`ifdef PAYLOAD_SUM_EN
    logic [15:0] r_sum;
    logic        r_sum_valid;

    // Running byte sum, cleared on frame accept, flagged after the last byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum       <= 16'd0;
            r_sum_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sum <= 16'd0;
            end else if (w_hs) begin
                r_sum <= r_sum + {8'd0, m_data};
            end
            r_sum_valid <= w_final;
        end
    end

    assign sum_out   = r_sum;
    assign sum_valid = r_sum_valid;
`else
    logic w_unused_final;
    assign w_unused_final = w_final;
`endif

endmodule

// File: doc/udp_payload_reader.md
Name: udp_payload_reader

Overview:
Drains a received UDP payload from the shared 32-bit dual-port payload RAM (read port) and emits it as a byte stream with valid/ready handshake. It feeds the downstream video/laser path.
The block is the reader counterpart of the RX-side RAM writer. It starts on the UDP receiver's frame-done pulse and uses the received UDP length field to bound the read.

Parameters:
ADDR_W, 9, RAM word-address width (512 words)
BASE_ADDR, 0, first RAM word address of the payload
RAM_RD_LAT, 1, cycles from ram_rd_addr change to valid ram_rd_data (1 or 2)
MAX_BYTES, 2048, payload clamp (4 * 2^ADDR_W)

Ports:
clk  in  1  system clock (gmii_rx_clk domain)
rst_n  in  1  asynchronous active-low reset
frame_done  in  1  single-cycle pulse: RAM holds a complete payload
udp_length  in  16  UDP length field (header+payload), sampled with frame_done
ram_rd_addr  out  ADDR_W  RAM read word address
ram_rd_data  in  32  RAM read data
m_data  out  8  payload byte
m_valid  out  1  m_data valid
m_ready  in  1  downstream accepts byte
m_last  out  1  marks final byte of payload, qualified by m_valid
busy  out  1  high from accepted frame_done until final byte handshake
trunc  out  1  sticky: a frame exceeded MAX_BYTES; cleared by next accepted frame
drop_cnt  out  8  frames ignored while busy; saturates at 255

Behaviour:
- Reset value of every output is 0; ram_rd_addr resets to BASE_ADDR. Reset is asynchronous and active-low, with one clock, clk. Reset mid-frame aborts immediately, and no m_last is produced.
- Payload byte count: bytes = udp_length - 8, computed in 16 bits.
  - udp_length <= 8: frame accepted, no output, busy stays 0, state stays IDLE.
  - bytes > MAX_BYTES: clamp to MAX_BYTES and set trunc.
- Byte order: word bits [31:24] first, then [23:16], [15:8], [7:0].
- Final word: only the remaining 1-4 bytes are emitted; the unused low bytes are discarded.
- State machine:
  - IDLE: on frame_done with bytes > 0, latch the count, set ram_rd_addr = BASE_ADDR, set busy, go to WAIT.
  - WAIT: count RAM_RD_LAT cycles, then capture ram_rd_data into the word register and go to SEND.
  - SEND: m_valid = 1 and m_data = the current byte. On m_valid && m_ready, advance the byte index and decrement the remaining count.
    - Remaining count hits 0: go to IDLE, clear busy.
    - Index wraps 3->0: increment ram_rd_addr and go to WAIT.
- m_last = m_valid && remaining == 1.
- Handshake rules:
  - m_data and m_last stay stable while m_valid && !m_ready.
  - m_valid is never deasserted without a handshake, except on reset.
- First m_valid rises RAM_RD_LAT+1 cycles after the cycle in which frame_done is sampled. Between words there are RAM_RD_LAT+1 bubble cycles.
- ram_rd_addr wraps modulo 2^ADDR_W.
- frame_done while busy is ignored and increments drop_cnt (saturating).
- frame_done in the same cycle as the final handshake is also dropped; a new frame is accepted only in IDLE.

Optional Feature:
PAYLOAD_SUM_EN
- Defined: adds outputs sum_out[15:0] and sum_valid.
  - sum_out is the 16-bit modular sum of all emitted bytes, cleared on frame accept.
  - sum_valid is a 1-cycle pulse the cycle after the m_last handshake.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package eth_pkg holds:
  - UDP_HDR_BYTES = 8
  - the reader state enum {IDLE, WAIT, SEND}
  - the default RAM geometry constants, shared with the RAM writer and udp instantiation
- One sub-module is natural: word_byte_unpacker, which holds the 32-bit word register, the byte index and the stable-while-stalled mux.

Test Plan:
- Preload the RAM at BASE_ADDR with words "HELL","O AL","INX ","AV60","45\r\n", then pulse frame_done with udp_length=28. Expect 20 bytes "HELLO ALINX AV6045\r\n" in order, m_last on byte 20 ("\n"), and busy falling after that handshake.
- udp_length=14 (6 bytes) with m_ready held high. Expect "HELLO " then stop: m_last on byte 6, bytes 7-8 of word 2 not emitted, first m_valid RAM_RD_LAT+1 cycles after frame_done.
- Same frame with m_ready toggling 1010. Expect m_data/m_last stable during each stall and the byte sequence unchanged.
- udp_length=8 and udp_length=0. Expect no m_valid, busy=0 and drop_cnt unchanged.
- Second frame_done during a frame, then 300 further pulses while busy. Expect drop_cnt=1 after the first and saturation at 255; the output stream is unaffected.
- udp_length=4000. Expect exactly 2048 bytes, trunc=1, and ram_rd_addr wrapping back to BASE_ADDR.
- Deassert rst_n mid-SEND. Expect all outputs 0 immediately with no m_last; a following 28-byte frame is emitted correctly.
